fifo_write_full: RTL and testbench

FIFO_WRITE_FULL -- requirements
Module: fifo_write_full

---
 rtl/fifo_write_full.sv | 82 ++++++++
 tb/tb_fifo_write_full.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_full.sv
// Write-clock half of an asynchronous FIFO: read-pointer synchronizer, binary/Gray
// write pointer, and registered full, almost-full, overflow and fill-level flags.
module fifo_write_full #(
    parameter int size      = 8,
    parameter int af_margin = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            winc,
    input  logic [size-1:0] rptr_async,
    output logic [size-1:0] wq2_rptr,
    output logic [size-2:0] wadr,
    output logic [size-1:0] wptr,
    output logic            wfull,
    output logic            walmost_full,
    output logic            wovf,
    output logic [size-1:0] wcount
);

    localparam int unsigned     DEPTH    = 1 << (size - 1);
    localparam logic [size-1:0] AF_LEVEL = size'(DEPTH - af_margin);

    logic [size-1:0] wq1_q, wq2_q;
    logic [size-1:0] wbin_q, wbin_d;
    logic [size-2:0] wadr_q, wadr_d;
    logic [size-1:0] wptr_q, wptr_d;
    logic [size-1:0] wcount_q, wcount_d;
    logic            wfull_q, wfull_d;
    logic            waf_q, waf_d;
    logic            wovf_q, wovf_d;
    logic [size-1:0] rbin;

    always_comb begin
        wbin_d = wbin_q + {{(size-1){1'b0}}, (winc & ~wfull_q)};
        wadr_d = wbin_d[size-2:0];
        wptr_d = wbin_d ^ (wbin_d >> 1);

        // Gray to binary: each bit is the XOR of all Gray bits at or above it.
        rbin = '0;
        for (int unsigned i = 0; i < size; i++) begin
            rbin[i] = ^(wq2_q >> i);
        end

        wcount_d = wbin_d - rbin;
        wfull_d  = (wptr_d == {~wq2_q[size-1:size-2], wq2_q[size-3:0]});
        waf_d    = (wcount_d >= AF_LEVEL);
        wovf_d   = wovf_q | (winc & wfull_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wq1_q    <= '0;
            wq2_q    <= '0;
            wbin_q   <= '0;
            wadr_q   <= '0;
            wptr_q   <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
            waf_q    <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wq1_q    <= rptr_async;
            wq2_q    <= wq1_q;
            wbin_q   <= wbin_d;
            wadr_q   <= wadr_d;
            wptr_q   <= wptr_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
            waf_q    <= waf_d;
            wovf_q   <= wovf_d;
        end
    end

    assign wq2_rptr     = wq2_q;
    assign wadr         = wadr_q;
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = waf_q;
    assign wovf         = wovf_q;
    assign wcount       = wcount_q;

endmodule

// File: tb/tb_fifo_write_full.sv
// Scoreboard bench for fifo_write_full at size=4 (depth 8), af_margin=2.
module tb_fifo_write_full;

    localparam int SIZE = 4;
    localparam int AFM  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic [3:0] rptr_async;
    logic [3:0] wq2_rptr;
    logic [2:0] wadr;
    logic [3:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic       wovf;
    logic [3:0] wcount;

    fifo_write_full #(.size(SIZE), .af_margin(AFM)) dut (
        .clk         (clk),
        .rst         (rst),
        .winc        (winc),
        .rptr_async  (rptr_async),
        .wq2_rptr    (wq2_rptr),
        .wadr        (wadr),
        .wptr        (wptr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wovf        (wovf),
        .wcount      (wcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q2;
        int wadr;
        int wptr;
        int wcount;
        int full;
        int af;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: write count, two sync stages (Gray), full and overflow flags.
    int m_wbin, m_s1, m_s2;
    int m_full, m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int g2b(input int g);
        return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
    endfunction

    function automatic logic [3:0] model_wptr();
        return 4'((m_wbin ^ (m_wbin >> 1)) & 15);
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq("wq2_rptr", 32'(wq2_rptr), 32'(e.q2));
            check_eq("wadr", 32'(wadr), 32'(e.wadr));
            check_eq("wptr", 32'(wptr), 32'(e.wptr));
            check_eq("wcount", 32'(wcount), 32'(e.wcount));
            check_eq("wfull", 32'(wfull), 32'(e.full));
            check_eq("walmost_full", 32'(walmost_full), 32'(e.af));
            check_eq("wovf", 32'(wovf), 32'(e.ovf));
        end
    endtask

    task automatic step(input bit r, input bit w, input logic [3:0] rp);
        exp_t e;
        int   nx, cnt;
        rst        = r;
        winc       = w;
        rptr_async = rp;
        if (r) begin
            m_wbin = 0; m_s1 = 0; m_s2 = 0; m_full = 0; m_ovf = 0;
            e.q2 = 0; e.wadr = 0; e.wptr = 0; e.wcount = 0;
            e.full = 0; e.af = 0; e.ovf = 0;
        end else begin
            nx  = (m_wbin + ((w && m_full == 0) ? 1 : 0)) & 15;
            cnt = (nx - g2b(m_s2)) & 15;
            if (w && m_full != 0) m_ovf = 1;
            m_full   = (cnt == 8) ? 1 : 0;
            m_s2     = m_s1;
            m_s1     = int'(rp);
            m_wbin   = nx;
            e.q2     = m_s2;
            e.wadr   = nx & 7;
            e.wptr   = (nx ^ (nx >> 1)) & 15;
            e.wcount = cnt;
            e.full   = m_full;
            e.af     = (cnt >= 8 - AFM) ? 1 : 0;
            e.ovf    = m_ovf;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    int  maxcnt;
    bit  bad_flag, seen_1000, wrapped;
    logic [3:0] rp_r;

    initial begin
        rst = 1'b1; winc = 1'b0; rptr_async = '0;
        @(negedge clk);

        // Reset state, then fill to full with eight writes.
        step(1, 0, 4'h0);
        check_eq("reset_wcount", 32'(wcount), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 4'h0);
            check_eq("fill_wadr", 32'(wadr), 32'(i % 8));
        end
        check_eq("full_wptr", 32'(wptr), 32'hC);
        check_eq("full_flag", 32'(wfull), 32'd1);
        check_eq("full_wcount", 32'(wcount), 32'd8);

        // Write while full is dropped and overflow sticks.
        step(0, 1, 4'h0);
        check_eq("ovf_wptr", 32'(wptr), 32'hC);
        check_eq("ovf_wadr", 32'(wadr), 32'd0);
        check_eq("ovf_set", 32'(wovf), 32'd1);
        step(0, 0, 4'h0);
        check_eq("ovf_sticky", 32'(wovf), 32'd1);

        // Read pointer advance reaches wfull/wcount three edges later.
        step(0, 0, 4'h1);
        check_eq("rd_e1_full", 32'(wfull), 32'd1);
        step(0, 0, 4'h1);
        check_eq("rd_e2_q2", 32'(wq2_rptr), 32'h1);
        check_eq("rd_e2_full", 32'(wfull), 32'd1);
        step(0, 0, 4'h1);
        check_eq("rd_e3_full", 32'(wfull), 32'd0);
        check_eq("rd_e3_wcount", 32'(wcount), 32'd7);

        // Almost-full threshold at depth - af_margin = 6.
        step(1, 0, 4'h0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 4'h0);
            if (i == 5) check_eq("af_at5", 32'(walmost_full), 32'd0);
        end
        check_eq("af_at6", 32'(walmost_full), 32'd1);
        check_eq("af_wcount", 32'(wcount), 32'd6);
        check_eq("af_full", 32'(wfull), 32'd0);

        // Twenty writes with the read pointer trailing wptr by one cycle.
        step(1, 0, 4'h0);
        maxcnt = 0; bad_flag = 0; seen_1000 = 0; wrapped = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, model_wptr());
            if (int'(wcount) > maxcnt) maxcnt = int'(wcount);
            if (wfull || wovf) bad_flag = 1;
            if (wptr == 4'b1000) seen_1000 = 1;
            if (seen_1000 && wptr == 4'b0000) wrapped = 1;
        end
        check_eq("trk_noflag", 32'(bad_flag), 32'd0);
        check_eq("trk_wrap", 32'({seen_1000, wrapped}), 32'b11);
        check_eq("trk_maxcnt_le4", 32'(maxcnt <= 4), 32'd1);

        // Reset from wcount=5 with overflow set and winc high.
        step(1, 0, 4'h0);
        for (int i = 0; i < 9; i++) step(0, 1, 4'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 4'b0010);
        check_eq("pre_rst_wcount", 32'(wcount), 32'd5);
        check_eq("pre_rst_ovf", 32'(wovf), 32'd1);
        step(1, 1, 4'h0);
        check_eq("rst_outs", 32'({wq2_rptr, wadr, wptr, wfull, walmost_full, wovf, wcount}), 32'd0);
        step(0, 1, 4'h0);
        check_eq("post_rst_wadr", 32'(wadr), 32'd1);
        check_eq("post_rst_wptr", 32'(wptr), 32'b0001);

        // Random write traffic with a read pointer that occasionally catches up.
        rp_r = '0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) rp_r = model_wptr();
            step(0, bit'($urandom_range(1)), rp_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
